// File: rtl/half_subtractor_pkg.sv
// Shared definitions for the half subtractor slice.
// Provides the per-lane result type and the single-bit subtract function
// used by every lane, so the truth table lives in exactly one place.
package half_subtractor_pkg;

  // Result of one 1-bit subtraction x - y.
  typedef struct packed {
    logic d;  // difference
    logic b;  // borrow-out
  } hs_res_t;

  // One-bit half subtraction: d = x ^ y, b = ~x & y.
  function automatic hs_res_t hs_bit(input logic x, input logic y);
    hs_res_t res;
    res.d = x ^ y;
    res.b = ~x & y;
    return res;
  endfunction

endpackage : half_subtractor_pkg

// File: rtl/half_subtractor_lane.sv
// One combinational half-subtractor lane.
// Ports:
//   x  in  1  minuend bit
//   y  in  1  subtrahend bit
//   d  out 1  difference bit (x ^ y)
//   b  out 1  borrow-out bit (~x & y)
module half_subtractor_lane
  import half_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  hs_res_t res_s;

  assign res_s = hs_bit(x, y);
  assign d     = res_s.d;
  assign b     = res_s.b;

endmodule : half_subtractor_lane

// File: rtl/half_subtractor.sv
// Lane-parallel half subtractor with optional output register.
// Each of WIDTH lanes computes X[i] - Y[i] independently; no borrow
// travels between lanes, so this is a leaf feeding external borrow chains.
// Parameters:
//   WIDTH    number of independent 1-bit lanes (>= 1)
//   REG_OUT  1: D/B/vld_o registered (latency 1); 0: combinational
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   X      in   WIDTH  minuend per lane
//   Y      in   WIDTH  subtrahend per lane
//   vld_i  in   1      input sample valid
//   D      out  WIDTH  difference per lane
//   B      out  WIDTH  borrow-out per lane
//   vld_o  out  1      D/B valid
module half_subtractor #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             vld_i,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] B,
  output logic             vld_o
);

  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] b_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_lane u_lane (
      .x (X[i]),
      .y (Y[i]),
      .d (d_s[i]),
      .b (b_s[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] b_r;
    logic             vld_r;

    // Output register: capture lane results on a valid sample, otherwise hold
    // D/B and drop valid. Reset clears everything, discarding any result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_r   <= {WIDTH{1'b0}};
        b_r   <= {WIDTH{1'b0}};
        vld_r <= 1'b0;
      end else if (vld_i) begin
        d_r   <= d_s;
        b_r   <= b_s;
        vld_r <= 1'b1;
      end else begin
        vld_r <= 1'b0;
      end
    end

    assign D     = d_r;
    assign B     = b_r;
    assign vld_o = vld_r;
  end else begin : g_comb
    // Clock and reset have no role in the combinational variant.
    logic unused_s;
    assign unused_s = clk ^ rst_n;

    assign D     = d_s;
    assign B     = b_s;
    assign vld_o = vld_i;
  end

endmodule : half_subtractor

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor: registered WIDTH=1 and WIDTH=4
// instances share clock, reset and valid; a combinational WIDTH=1 instance
// covers REG_OUT=0. Expected {D,B} values are hand-computed constants.
module tb_half_subtractor;

  logic       clk;
  logic       rst_n;
  logic       vld_i;
  logic       x1, y1;
  logic [3:0] x4, y4;
  logic       d1, b1, vo1;
  logic [3:0] d4, b4;
  logic       vo4;
  logic       xc, yc, vc;
  logic       dc, bc, voc;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [1:0] q1[$];
  logic [7:0] q4[$];

  half_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .X(x1), .Y(y1), .vld_i(vld_i),
    .D(d1), .B(b1), .vld_o(vo1));

  half_subtractor #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .X(x4), .Y(y4), .vld_i(vld_i),
    .D(d4), .B(b4), .vld_o(vo4));

  half_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .X(xc), .Y(yc), .vld_i(vc),
    .D(dc), .B(bc), .vld_o(voc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever registered outputs are valid.
  initial begin
    logic [1:0] e1;
    logic [7:0] e4;
    forever begin
      @(posedge clk);
      #1;
      if (vo1) begin
        n_pop++;
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut1_unexpected: got %0h expected none", {d1, b1});
        end else begin
          e1 = q1.pop_front();
          chk("dut1_DB", {30'd0, d1, b1}, {30'd0, e1});
        end
      end
      if (vo4) begin
        if (q4.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut4_unexpected: got %0h expected none", {d4, b4});
        end else begin
          e4 = q4.pop_front();
          chk("dut4_DB", {24'd0, d4, b4}, {24'd0, e4});
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Stimulus tables: {x, y, exp_d, exp_b}.
  logic [3:0]  tv1[5] = '{4'b0000, 4'b0111, 4'b1010, 4'b1100, 4'b0111};
  logic [15:0] tv4[5] = '{
    {4'b1100, 4'b1010, 4'b0110, 4'b0010},
    {4'b1111, 4'b0000, 4'b1111, 4'b0000},
    {4'b0000, 4'b1111, 4'b1111, 4'b1111},
    {4'b0101, 4'b0011, 4'b0110, 4'b0010},
    {4'b1001, 4'b0110, 4'b1111, 4'b0110}};

  initial begin
    logic [3:0]  v1;
    logic [15:0] v4;
    rst_n = 1'b0; vld_i = 1'b0; x1 = 1'b0; y1 = 1'b0; x4 = 4'd0; y4 = 4'd0;
    xc = 1'b0; yc = 1'b0; vc = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dut1", {29'd0, d1, b1, vo1}, 32'd0);
    chk("reset_dut4", {23'd0, d4, b4, vo4}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back valid vectors (truth table on WIDTH=1, lane independence on WIDTH=4).
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v1 = tv1[i]; v4 = tv4[i];
      vld_i = 1'b1;
      x1 = v1[3]; y1 = v1[2];
      x4 = v4[15:12]; y4 = v4[11:8];
      q1.push_back(v1[1:0]);
      q4.push_back(v4[7:0]);
    end

    // Hold: vld_i low while X/Y change; outputs keep last result.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vld_i = 1'b0;
      x1 = ~x1; y1 = 1'b0; x4 = 4'(i + 3); y4 = 4'(~i);
      @(posedge clk); #2;
      chk("hold_dut1", {29'd0, d1, b1, vo1}, {29'd0, 1'b1, 1'b1, 1'b0});
      chk("hold_dut4", {23'd0, d4, b4, vo4}, {23'd0, 4'b1111, 4'b0110, 1'b0});
    end

    // Asynchronous reset mid-cycle.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dut1", {29'd0, d1, b1, vo1}, 32'd0);
    chk("async_rst_dut4", {23'd0, d4, b4, vo4}, 32'd0);

    // Valid sample while reset is low produces nothing.
    @(negedge clk);
    vld_i = 1'b1; x1 = 1'b0; y1 = 1'b1; x4 = 4'b0000; y4 = 4'b1111;
    @(posedge clk); #2;
    chk("rst_discard", {22'd0, vo1, vo4, d4, b4}, 32'd0);

    // Release and first capture after reset.
    @(negedge clk);
    rst_n = 1'b1; vld_i = 1'b1;
    x1 = 1'b1; y1 = 1'b0; x4 = 4'b0011; y4 = 4'b0101;
    q1.push_back(2'b10);
    q4.push_back({4'b0110, 4'b0100});
    @(negedge clk);
    vld_i = 1'b0;

    // Combinational variant.
    xc = 1'b0; yc = 1'b1; vc = 1'b1; #1;
    chk("comb_01", {29'd0, dc, bc, voc}, {29'd0, 3'b111});
    xc = 1'b1; yc = 1'b1; vc = 1'b0; #1;
    chk("comb_11", {29'd0, dc, bc, voc}, {29'd0, 3'b000});
    xc = 1'b1; yc = 1'b0; vc = 1'b1; #1;
    chk("comb_10", {29'd0, dc, bc, voc}, {29'd0, 3'b101});

    repeat (3) @(negedge clk);
    chk("q_drained", {16'd0, 8'(q1.size()), 8'(q4.size())}, 32'd0);
    chk("result_count", n_pop, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_half_subtractor
